// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the counter sequencer.
package count_seq_pkg;

  localparam int DEF_WRAP_WIDTH = 8;
  localparam int DEF_GAP_WIDTH  = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ENABLE,
    SEQ_GAP,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/count_sequencer.sv
// Drives a downstream counter's enable for a programmed number of wraps,
// with an optional idle gap after every enable cycle, then pulses done.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WRAP_WIDTH = DEF_WRAP_WIDTH,
  parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WRAP_WIDTH-1:0] num_wraps,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  carryout,
  output logic                  enb,
  output logic                  busy,
  output logic                  done,
  output logic [WRAP_WIDTH-1:0] wrap_count,
  output seq_state_e            dbg_state
);

  // Handshake: start is a request taken only in IDLE (ignored otherwise);
  // abort is a stop request honoured only while busy and beats any carry.
  seq_state_e            r_state;
  seq_state_e            w_next_state;
  logic [WRAP_WIDTH-1:0] r_num_wraps_q;
  logic [GAP_WIDTH-1:0]  r_gap_q;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic [WRAP_WIDTH-1:0] r_wrap_count;
  logic                  w_enb;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_start_ok;
  logic                  w_wrap_hit;
  logic [WRAP_WIDTH-1:0] w_wrap_inc;

  assign w_start_ok = (r_state == SEQ_IDLE) && start;
  assign w_wrap_hit = w_enb && carryout;
  assign w_wrap_inc = r_wrap_count + WRAP_WIDTH'(1);

  always_comb begin
    w_next_state = r_state;
    w_enb        = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (start) begin
          w_next_state = (num_wraps == '0) ? SEQ_DONE : SEQ_ENABLE;
        end
      end
      SEQ_ENABLE: begin
        w_busy = 1'b1;
        w_enb  = ~abort;
        if (abort) begin
          w_next_state = SEQ_IDLE;
        end else if (carryout && (w_wrap_inc == r_num_wraps_q)) begin
          w_next_state = SEQ_DONE;
        end else if (r_gap_q != '0) begin
          w_next_state = SEQ_GAP;
        end
      end
      SEQ_GAP: begin
        w_busy = 1'b1;
        if (abort) begin
          w_next_state = SEQ_IDLE;
        end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
          w_next_state = SEQ_ENABLE;
        end
      end
      SEQ_DONE: begin
        w_done       = 1'b1;
        w_next_state = SEQ_IDLE;
      end
      default: w_next_state = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num_wraps_q <= '0;
      r_gap_q       <= '0;
    end else if (w_start_ok) begin
      r_num_wraps_q <= num_wraps;
      r_gap_q       <= gap;
    end
  end

  // Loaded on each ENABLE->GAP hop so every gap lasts exactly r_gap_q cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if ((r_state == SEQ_ENABLE) && (w_next_state == SEQ_GAP)) begin
      r_gap_cnt <= r_gap_q;
    end else if (r_state == SEQ_GAP) begin
      r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap_count <= '0;
    end else if (w_start_ok) begin
      r_wrap_count <= '0;
    end else if (w_wrap_hit) begin
      r_wrap_count <= w_wrap_inc;
    end
  end

  assign enb        = w_enb;
  assign busy       = w_busy;
  assign done       = w_done;
  assign wrap_count = r_wrap_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a 4-bit counter as the load, a cycle-level
// reference model of the run rules, directed runs plus a randomized phase.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int WW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] num_wraps = '0;
  logic [GW-1:0] gap = '0;
  logic          carryout;
  logic          enb;
  logic          busy;
  logic          done;
  logic [WW-1:0] wrap_count;
  seq_state_e    dbg_state;
  logic [3:0]    ctr;

  // clock / reset block
  always #5 clk = ~clk;

  count_sequencer #(.WRAP_WIDTH(WW), .GAP_WIDTH(GW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_wraps  (num_wraps),
    .gap        (gap),
    .carryout   (carryout),
    .enb        (enb),
    .busy       (busy),
    .done       (done),
    .wrap_count (wrap_count),
    .dbg_state  (dbg_state)
  );

  // The Counter being sequenced: WIDTH=4, carry on terminal count while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) ctr <= '0;
    else if (enb) ctr <= ctr + 4'd1;
  end
  assign carryout = enb && (ctr == 4'd15);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is "remaining gap cycles" plus "wraps so far".
  bit m_valid = 0;
  bit m_running = 0;
  bit m_done_now = 0;
  int m_gap_left = 0;
  int m_wraps = 0;
  int m_target = 0;
  int m_gap = 0;
  int enb_cycles = 0;
  int busy_cycles = 0;
  int done_cnt = 0;
  logic [WW-1:0] exp_q[$];

  always @(negedge clk) begin
    bit m_en;
    m_en = m_running && (m_gap_left == 0) && !abort;
    if (m_valid) begin
      check("enb", enb, m_en);
      check("busy", busy, m_running);
      check("done", done, m_done_now);
      exp_q.push_back(WW'(m_wraps));
      check("wrap_count", wrap_count, exp_q.pop_front());
    end
    enb_cycles  += int'(enb);
    busy_cycles += int'(busy);
    done_cnt    += int'(done);
    if (!rst_n) begin
      m_running = 0; m_done_now = 0; m_gap_left = 0; m_wraps = 0;
      m_target = 0; m_gap = 0; m_valid = 1;
    end else if (m_done_now) begin
      m_done_now = 0;
    end else if (!m_running) begin
      if (start) begin
        m_target = int'(num_wraps); m_gap = int'(gap); m_wraps = 0;
        enb_cycles = 0; busy_cycles = 0; done_cnt = 0;
        if (m_target == 0) m_done_now = 1;
        else begin m_running = 1; m_gap_left = 0; end
      end
    end else if (abort) begin
      m_running = 0;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      if (ctr == 4'd15) m_wraps++;
      if (m_wraps == m_target) begin m_running = 0; m_done_now = 1; end
      else m_gap_left = m_gap;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int nw, input int g);
    num_wraps = WW'(nw); gap = GW'(g); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check(name, done_cnt != 0, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_enb", enb, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wrap", wrap_count, 0);

    // continuous run
    do_start(2, 0);
    wait_done("cont_done_seen", 100);
    tick(); tick();
    check("cont_enb_cycles", enb_cycles, 32);
    check("cont_busy_cycles", busy_cycles, 32);
    check("cont_done_cnt", done_cnt, 1);
    check("cont_wrap", wrap_count, 2);

    // gapped run
    do_start(1, 2);
    wait_done("gap_done_seen", 200);
    tick();
    check("gap_enb_cycles", enb_cycles, 16);
    check("gap_busy_cycles", busy_cycles, 46);
    check("gap_wrap", wrap_count, 1);

    // zero target
    do_start(0, 3);
    wait_done("zero_done_seen", 5);
    tick();
    check("zero_enb_cycles", enb_cycles, 0);
    check("zero_busy_cycles", busy_cycles, 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_wrap", wrap_count, 0);

    // abort on the 20th enable cycle
    do_start(3, 0);
    n = 0;
    while (enb_cycles < 19 && n < 100) begin tick(); n++; end
    check("abort_reach_19", enb_cycles, 19);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort_enb_cycles", enb_cycles, 19);
    check("abort_busy", busy, 0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_wrap", wrap_count, 1);
    do_start(2, 0);
    check("restart_wrap_clear", wrap_count, 0);
    wait_done("restart_done_seen", 100);
    tick();

    // ignored start while busy
    do_start(2, 1);
    repeat (5) tick();
    num_wraps = WW'(5); gap = GW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_done_seen", 200);
    tick();
    check("ign_wrap", wrap_count, 2);
    check("ign_done_cnt", done_cnt, 1);

    // mid-run reset
    do_start(3, 0);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_enb", enb, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap_count, 0);
    repeat (5) tick();
    check("rst_no_done", done_cnt, 0);

    // randomized phase, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      num_wraps = WW'($urandom_range(0, 3));
      gap       = GW'($urandom_range(0, 3));
      rst_n     = !($urandom_range(0, 799) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
